// File: rtl/gpio_apb_master.sv
// ---------------------------------------------------------------------------
// gpio_apb_master
//   APB initiator: turns a valid/ready command stream into single APB
//   transfers and returns exactly one response per command on a separate
//   valid/ready channel. A transfer moves through IDLE -> SETUP -> ACCESS -> RESP.
//   All APB and rsp_* outputs come straight from registers.
//
// Build option:
//   APB_MASTER_TIMEOUT_EN - when defined, a watchdog aborts an ACCESS phase
//   after TIMEOUT_CYCLES wait states and reports rsp_err = rsp_timeout = 1.
//   When it is undefined there is no counter and rsp_timeout is tied low.
//
// Ports:
//   PCLK, PRESETn                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_write/cmd_addr/cmd_wdata   command payload
//   rsp_valid/rsp_ready            response handshake
//   rsp_rdata/rsp_err/rsp_timeout  response payload
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA  APB request outputs
//   PRDATA/PREADY/PSLVERR          APB completion inputs
//   busy                           high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module gpio_apb_master #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int unsigned            CNT_W    = 16;
  localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rsp_timeout_q;

  // cnt_q holds the number of wait states already seen in this ACCESS phase,
  // so the limit is reached on the wait state that would make it TIMEOUT_CYCLES.
  // PREADY high in that same cycle wins and completes normally.
  assign timeout_hit = (state_q == S_ACCESS) && !PREADY && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETUP) begin
      cnt_d = '0;
    end else if (state_q == S_ACCESS && !PREADY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q         <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (timeout_hit) begin
        rsp_timeout_q <= 1'b1;
      end else if (state_q == S_ACCESS && PREADY) begin
        rsp_timeout_q <= 1'b0;
      end
    end
  end

  assign rsp_timeout = rsp_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          psel_d   = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        penable_d = 1'b1;
        state_d   = S_ACCESS;
      end
      S_ACCESS: begin
        if (PREADY) begin
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end else if (timeout_hit) begin
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        // The bus is already idle here; only the response side waits.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= S_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before the edge, independent of statement order.
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_gpio_apb_master.sv
// ---------------------------------------------------------------------------
// tb_gpio_apb_master
//   Self-checking bench for gpio_apb_master. A small APB slave model answers
//   after a configurable number of wait states; expected responses are pushed
//   to a scoreboard queue when a command is issued and popped when the DUT
//   presents rsp_valid. Build with +define+APB_MASTER_TIMEOUT_EN to exercise
//   the watchdog (TIMEOUT_CYCLES = 4 here).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpio_apb_master;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int TMO    = 4;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic              tmo;
  } rsp_t;

  logic              PCLK = 1'b0;
  logic              PRESETn;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DATA_W-1:0] rsp_rdata;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic              busy;

  gpio_apb_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0    = 0;
  rsp_t sb[$];

  // Slave model knobs.
  int              wait_cfg  = 0;
  logic [DATA_W-1:0] rdata_cfg = '0;
  logic            err_cfg   = 1'b0;
  logic            noise_err = 1'b0;
  logic            stuck     = 1'b0;
  int              acc_cnt   = 0;

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave answers on the falling edge so the DUT sees stable inputs at the
  // next rising edge. PSLVERR outside the completing cycle carries noise.
  always @(negedge PCLK) begin
    PRDATA = rdata_cfg;
    if (PSEL && PENABLE) begin
      PREADY  = !stuck && (acc_cnt >= wait_cfg);
      PSLVERR = PREADY ? err_cfg : noise_err;
      acc_cnt = acc_cnt + 1;
    end else begin
      acc_cnt = 0;
      PREADY  = 1'b0;
      PSLVERR = noise_err;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_pwrite", PWRITE, 0);
    check("rst_paddr", PADDR, 0);
    check("rst_pwdata", PWDATA, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
  endtask

  // Called at a falling edge with the DUT in IDLE; returns at the falling
  // edge of the SETUP cycle.
  task automatic issue_cmd(input logic w, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input bit push, input rsp_t e);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    if (push) sb.push_back(e);
    c0 = cyc;
    @(negedge PCLK);
    // Scramble the payload so the bench sees whether the DUT latched it.
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = ~a;
    cmd_wdata = ~d;
    check("setup_psel", PSEL, 1);
    check("setup_penable", PENABLE, 0);
    check("setup_paddr", PADDR, a);
    check("setup_pwdata", PWDATA, d);
    check("setup_pwrite", PWRITE, w);
    check("setup_cmd_ready", cmd_ready, 0);
    check("setup_busy", busy, 1);
  endtask

  // Waits (bounded) for rsp_valid, holds off rsp_ready for 'hold' cycles,
  // then pops the scoreboard and compares.
  task automatic wait_resp(input int hold);
    rsp_t e;
    int   n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge PCLK);
      n++;
    end
    check("rsp_valid_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    check("sb_has_entry", (sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    for (int k = 0; k < hold; k++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_rdata", rsp_rdata, e.rdata);
      check("bp_psel", PSEL, 0);
      check("bp_cmd_ready", cmd_ready, 0);
      @(negedge PCLK);
    end
    check("resp_psel", PSEL, 0);
    check("resp_penable", PENABLE, 0);
    check("resp_cmd_ready", cmd_ready, 0);
    check("rsp_rdata", rsp_rdata, e.rdata);
    check("rsp_err", rsp_err, e.err);
    check("rsp_timeout", rsp_timeout, e.tmo);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
    check("post_busy", busy, 0);
  endtask

  // One full transfer. exp_en is the number of cycles PENABLE must be high.
  task automatic do_xfer(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int waits,
                         input logic [DATA_W-1:0] srdata, input logic serr,
                         input logic noise, input int hold, input rsp_t e,
                         input int exp_en);
    int n_en;
    wait_cfg  = waits;
    rdata_cfg = srdata;
    err_cfg   = serr;
    noise_err = noise;
    rsp_ready = (hold == 0);
    issue_cmd(w, a, d, 1'b1, e);
    n_en = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge PCLK);
      if (!(PSEL && PENABLE)) break;
      n_en++;
      check("access_paddr", PADDR, a);
      check("access_pwdata", PWDATA, d);
      check("access_pwrite", PWRITE, w);
      check("access_cmd_ready", cmd_ready, 0);
    end
    check("penable_cycles", n_en, exp_en);
    wait_resp(hold);
    check("xfer_cycles", cyc - c0, 3 + exp_en + hold);
    noise_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rsp_t e;
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge PCLK);
    check_reset_values();
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("idle_cmd_ready", cmd_ready, 1);
    check("idle_busy", busy, 0);

    // Write, zero wait: rsp_rdata must be 0 even though PRDATA is not.
    e = '{rdata: '0, err: 1'b0, tmo: 1'b0};
    do_xfer(1'b1, 8'h04, 32'hA5A5_0F0F, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, 0, e, 1);

    // Read with 3 wait states; PSLVERR noise during waits must be ignored.
    e = '{rdata: 32'h1234_5678, err: 1'b0, tmo: 1'b0};
    do_xfer(1'b0, 8'h08, 32'h55AA_55AA, 3, 32'h1234_5678, 1'b0, 1'b1, 0, e, 4);

    // Slave error on a read.
    e = '{rdata: 32'h0BAD_F00D, err: 1'b1, tmo: 1'b0};
    do_xfer(1'b0, 8'hFC, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 1'b0, 0, e, 1);

    // Slave error on a write.
    e = '{rdata: '0, err: 1'b1, tmo: 1'b0};
    do_xfer(1'b1, 8'h30, 32'h0000_00FF, 1, 32'hFFFF_FFFF, 1'b1, 1'b0, 0, e, 2);

    // Response backpressure for 5 cycles.
    e = '{rdata: 32'h1357_9BDF, err: 1'b0, tmo: 1'b0};
    do_xfer(1'b0, 8'h20, 32'h0, 0, 32'h1357_9BDF, 1'b0, 1'b0, 5, e, 1);

    // A few mixed transfers with random wait states and payloads.
    for (int t = 0; t < 6; t++) begin
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, r;
      int                ws;
      w  = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom);
      d  = $urandom;
      r  = $urandom;
      ws = $urandom_range(0, 2);
      e  = '{rdata: (w ? '0 : r), err: 1'b0, tmo: 1'b0};
      do_xfer(w, a, d, ws, r, 1'b0, 1'b0, 0, e, ws + 1);
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Slave never ready: abort after TMO wait states with rdata forced to 0.
    stuck = 1'b1;
    e = '{rdata: '0, err: 1'b1, tmo: 1'b1};
    do_xfer(1'b0, 8'h40, 32'h0, 0, 32'h7777_7777, 1'b0, 1'b0, 0, e, TMO);
    stuck = 1'b0;
`else
    // Without the watchdog the master waits for PREADY indefinitely.
    stuck     = 1'b1;
    wait_cfg  = 0;
    rdata_cfg = 32'hCAFE_F00D;
    rsp_ready = 1'b1;
    e = '{rdata: 32'hCAFE_F00D, err: 1'b0, tmo: 1'b0};
    issue_cmd(1'b0, 8'h40, 32'h0, 1'b1, e);
    repeat (1000) @(negedge PCLK);
    check("stuck_psel", PSEL, 1);
    check("stuck_penable", PENABLE, 1);
    check("stuck_busy", busy, 1);
    check("stuck_rsp_valid", rsp_valid, 0);
    stuck = 1'b0;
    wait_resp(0);
`endif

    // Reset during a wait state: outputs clear without a clock edge and no
    // response is produced.
    wait_cfg  = 10;
    rsp_ready = 1'b1;
    e = '{rdata: '0, err: 1'b0, tmo: 1'b0};
    issue_cmd(1'b0, 8'h50, 32'h1111_2222, 1'b0, e);
    repeat (2) @(negedge PCLK);
    check("pre_rst_penable", PENABLE, 1);
    #2 PRESETn = 1'b0;
    #1;
    check_reset_values();
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("no_spurious_rsp", rsp_valid, 0);
    check("sb_empty_after_rst", sb.size(), 0);

    // Normal write after recovery.
    e = '{rdata: '0, err: 1'b0, tmo: 1'b0};
    do_xfer(1'b1, 8'h0C, 32'hFEED_0001, 0, 32'h0, 1'b0, 1'b0, 0, e, 1);
    check("paddr_holds", PADDR, 8'h0C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gpio_apb_master.md
Name: gpio_apb_master

Overview:
APB initiator that turns a simple valid/ready command stream into APB transfers. It drives the GPIO bank's APB slave port, or any APB slave using the same PADDR/PWDATA/PRDATA widths. It is used by the boot sequencer and testbench-free bring-up logic to program direction, output and interrupt registers, and to read back input and status registers. Each command yields exactly one response on a separate valid/ready channel.

Parameters:
ADDR_W, 8, width of cmd_addr and PADDR
DATA_W, 32, width of write/read data
TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort (used only with the optional feature); legal range 1..65535

Ports:
PCLK  in  1  clock, all logic rising-edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  target register address
cmd_wdata  in  DATA_W  write data (ignored for reads)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  PSLVERR seen, or timeout
rsp_timeout  out  1  transfer aborted by watchdog
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  APB slave ready
PSLVERR  in  1  APB slave error
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock is PCLK. Reset is PRESETn, asynchronous and active-low.
- Reset values:
  - FSM = IDLE.
  - PSEL = PENABLE = PWRITE = 0; PADDR = 0; PWDATA = 0.
  - rsp_valid = rsp_err = rsp_timeout = 0; rsp_rdata = 0.
  - cmd_ready = 1 once reset is released; busy = 0.
- FSM states are IDLE, SETUP, ACCESS, RESP. All APB outputs and rsp_* outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
- SETUP (exactly 1 cycle): PSEL = 1, PENABLE = 0; go to ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - PADDR, PWDATA and PWRITE stay stable until PREADY is sampled high.
  - On PREADY = 1:
    - Capture PRDATA into rsp_rdata for reads; rsp_rdata = 0 for writes.
    - Capture PSLVERR into rsp_err.
    - Set rsp_valid = 1; drop PSEL and PENABLE to 0 on the next edge; go to RESP.
  - PREADY = 0 inserts wait states indefinitely, unless the optional feature is enabled.
- RESP:
  - rsp_valid and all rsp_* outputs hold until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, go to IDLE.
  - A new command is not accepted in the same cycle.
- Zero-wait-state throughput: one transfer per 4 cycles (IDLE, SETUP, ACCESS, RESP) when rsp_ready is tied high.
- cmd_ready = 0 in SETUP, ACCESS and RESP. cmd_valid is ignored there; no queuing.
- PSLVERR is sampled only in the cycle where PREADY = 1 in ACCESS. It is ignored in all other cycles.
- PWDATA is driven with the latched value even for reads (don't-care for the slave). PADDR holds its last value after the transfer ends.
- Reset asserted mid-transfer (any state): all outputs return to reset values immediately, with no response issued. The slave sees PSEL fall asynchronously.
- Response backpressure never stalls the APB bus: the bus is already idle in RESP.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Enabled:
  - A counter clears on entry to ACCESS and increments on each ACCESS cycle with PREADY = 0.
  - When it reaches TIMEOUT_CYCLES with PREADY still 0: drop PSEL/PENABLE, set rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, and go to RESP.
  - PREADY = 1 in the same cycle as the limit is a normal completion, not a timeout.
- Disabled: no counter logic; rsp_timeout tied 0; ACCESS waits for PREADY forever.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd write addr 0x04 data 0xA5A5_0F0F; PREADY tied 1.
  - Response: PSEL high for 2 cycles, PENABLE high in the 2nd; PADDR = 0x04, PWDATA = 0xA5A5_0F0F; rsp_valid next cycle with rsp_rdata = 0, rsp_err = 0.
- Read, 3 wait states:
  - Stimulus: cmd read addr 0x08; PREADY low 3 ACCESS cycles, then 1 with PRDATA = 0x1234_5678.
  - Response: PENABLE high for 4 cycles; rsp_rdata = 0x1234_5678; cmd_ready low throughout.
- Slave error:
  - Stimulus: read addr 0xFC; PREADY = 1, PSLVERR = 1.
  - Response: rsp_err = 1, rsp_timeout = 0.
- Response backpressure:
  - Stimulus: rsp_ready held 0 for 5 cycles.
  - Response: rsp_valid and rsp_rdata stable; PSEL = 0; cmd_ready = 0 until handshake, then 1 the following cycle.
- Timeout (macro on, TIMEOUT_CYCLES = 4):
  - Stimulus: PREADY stuck 0.
  - Response: after 4 wait cycles PSEL = 0; rsp_valid with rsp_err = 1, rsp_timeout = 1.
  - Macro off: still in ACCESS after 1000 cycles.
- Reset mid-ACCESS:
  - Stimulus: PRESETn low during a wait state.
  - Response: PSEL/PENABLE/rsp_valid = 0 without a clock edge; after release, a new write completes normally.
